// File: rtl/slot_credit_ctrl.sv
// slot_credit_ctrl: credit/bet controller wrapped around the mode1 spin engine.
// Define SLOT_JACKPOT_EN to multiply the payout when the reels settle on JACKPOT_VAL.
module slot_credit_ctrl #(
  parameter int         CW           = 8,
  parameter int         BET          = 1,
  parameter int         PAYOUT       = 10,
  parameter int         SETTLE_CYC   = 16,
  parameter int         MAX_SPIN_CYC = 1000000,
  parameter logic [9:0] JACKPOT_VAL  = 10'd777,
  parameter int         JACKPOT_MULT = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin,
  input  logic          play_req,
  input  logic [9:0]    spin_out,
  input  logic          won,
  output logic          start,
  output logic [CW-1:0] credits,
  output logic          busy,
  output logic          win_flag,
  output logic          payout_pulse,
  output logic          fault
);

  localparam int SW = $clog2(SETTLE_CYC) + 1;
  localparam int TW = $clog2(MAX_SPIN_CYC) + 1;
  localparam logic [CW:0]   CRED_MAX     = {1'b0, {CW{1'b1}}};
  localparam logic [CW:0]   BET_W        = (CW+1)'(BET);
  localparam logic [CW:0]   AWARD_BASE   = (CW+1)'(PAYOUT);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MAX_SPIN_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    SPIN   = 2'd2,
    EVAL   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          coin_prev_r, play_prev_r;
  logic [9:0]    spin_prev_r;
  logic [SW-1:0] settle_cnt_r, settle_cnt_s;
  logic [TW-1:0] to_cnt_r, to_cnt_s;
  logic [CW-1:0] credits_r, credits_s;
  logic          start_r, busy_r, win_flag_r, payout_pulse_r, fault_r;
  logic          win_flag_s, payout_s, fault_s;
  logic [CW:0]   cred_add_s, cred_sub_s, credit_sum_s, award_s;
  logic          coin_edge_s, play_edge_s;

  assign coin_edge_s = coin & ~coin_prev_r;
  assign play_edge_s = play_req & ~play_prev_r;

`ifdef SLOT_JACKPOT_EN
  localparam logic [CW:0] AWARD_JP = (CW+1)'(PAYOUT * JACKPOT_MULT);
  assign award_s = (spin_out == JACKPOT_VAL) ? AWARD_JP : AWARD_BASE;
`else
  logic jackpot_unused_s;
  assign jackpot_unused_s = ^{JACKPOT_VAL, JACKPOT_MULT};
  assign award_s = AWARD_BASE;
`endif

  // Next-state, counter and credit-delta logic for the spin sequence
  always_comb begin
    state_s      = state_r;
    settle_cnt_s = settle_cnt_r;
    to_cnt_s     = to_cnt_r;
    win_flag_s   = win_flag_r;
    payout_s     = 1'b0;
    fault_s      = 1'b0;
    cred_add_s   = '0;
    cred_sub_s   = '0;
    case (state_r)
      IDLE: begin
        if (play_edge_s && ({1'b0, credits_r} >= BET_W)) begin
          state_s    = LAUNCH;
          cred_sub_s = BET_W;
        end else begin
          state_s    = IDLE;
        end
      end
      LAUNCH: begin
        settle_cnt_s = '0;
        to_cnt_s     = '0;
        state_s      = SPIN;
      end
      SPIN: begin
        // timeout wins a tie with settling: the spin is refunded, never judged
        if (to_cnt_r == TIMEOUT_LAST) begin
          fault_s    = 1'b1;
          cred_add_s = BET_W;
          state_s    = IDLE;
        end else if (settle_cnt_r == SETTLE_LAST) begin
          state_s    = EVAL;
        end else begin
          to_cnt_s = to_cnt_r + TW'(1);
          if (spin_out == spin_prev_r) begin
            settle_cnt_s = settle_cnt_r + SW'(1);
          end else begin
            settle_cnt_s = '0;
          end
        end
      end
      EVAL: begin
        win_flag_s = won;
        state_s    = IDLE;
        if (won) begin
          payout_s   = 1'b1;
          cred_add_s = award_s;
        end else begin
          payout_s   = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Combined credit update; subtraction only happens with credits >= BET so no underflow
  always_comb begin
    credit_sum_s = {1'b0, credits_r} + (CW+1)'(coin_edge_s) + cred_add_s - cred_sub_s;
    if (credit_sum_s > CRED_MAX) begin
      credits_s = CRED_MAX[CW-1:0];
    end else begin
      credits_s = credit_sum_s[CW-1:0];
    end
  end

  // State, history and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      coin_prev_r    <= 1'b0;
      play_prev_r    <= 1'b0;
      spin_prev_r    <= 10'd0;
      settle_cnt_r   <= '0;
      to_cnt_r       <= '0;
      credits_r      <= '0;
      start_r        <= 1'b0;
      busy_r         <= 1'b0;
      win_flag_r     <= 1'b0;
      payout_pulse_r <= 1'b0;
      fault_r        <= 1'b0;
    end else begin
      state_r        <= state_s;
      coin_prev_r    <= coin;
      play_prev_r    <= play_req;
      spin_prev_r    <= spin_out;
      settle_cnt_r   <= settle_cnt_s;
      to_cnt_r       <= to_cnt_s;
      credits_r      <= credits_s;
      start_r        <= (state_s == LAUNCH);
      busy_r         <= (state_s != IDLE);
      win_flag_r     <= win_flag_s;
      payout_pulse_r <= payout_s;
      fault_r        <= fault_s;
    end
  end

  assign start        = start_r;
  assign credits      = credits_r;
  assign busy         = busy_r;
  assign win_flag     = win_flag_r;
  assign payout_pulse = payout_pulse_r;
  assign fault        = fault_r;

endmodule

// File: tb/tb_slot_credit_ctrl.sv
// Self-checking bench for slot_credit_ctrl: vector table, corner sequences and
// randomized play against a transaction-level credit model.
module tb_slot_credit_ctrl;

  localparam int CW      = 8;
  localparam int MAXC    = 255;
  localparam int MAXSPIN = 64;
`ifdef SLOT_JACKPOT_EN
  localparam int JP_CRED = 50;
`else
  localparam int JP_CRED = 10;
`endif

  logic          clk = 1'b0;
  logic          rst, coin, play_req, won;
  logic [9:0]    spin_out;
  logic          start, busy, win_flag, payout_pulse, fault;
  logic [CW-1:0] credits;

  int errors = 0;
  int checks = 0;
  int n_start = 0, n_pay = 0, n_fault = 0, start_viol = 0;
  logic busy_q = 1'b0;

  slot_credit_ctrl #(.CW(CW), .MAX_SPIN_CYC(MAXSPIN)) dut (
    .clk(clk), .rst(rst), .coin(coin), .play_req(play_req), .spin_out(spin_out),
    .won(won), .start(start), .credits(credits), .busy(busy), .win_flag(win_flag),
    .payout_pulse(payout_pulse), .fault(fault)
  );

  always #5 clk = ~clk;

  // pulse counters, plus start-while-already-busy detection
  always @(negedge clk) begin
    if (start === 1'b1) begin
      n_start++;
      if (busy_q === 1'b1) start_viol++;
    end
    if (payout_pulse === 1'b1) n_pay++;
    if (fault === 1'b1) n_fault++;
    busy_q <= busy;
  end

  typedef struct {
    int         coins;
    bit         coin_play;
    bit         coin_eval;
    bit         toggle;
    bit         w;
    logic [9:0] sval;
    int         exp_cred;
    bit         exp_win;
    int         exp_pay;
    int         exp_fault;
  } vec_t;

  vec_t vecs[8];

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; coin = 1'b0; play_req = 1'b0; won = 1'b0; spin_out = 10'd0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic add_coins(input int n);
    repeat (n) begin
      coin = 1'b1; tick();
      coin = 1'b0; tick();
    end
  endtask

  task automatic launch(input bit cp);
    play_req = 1'b1; coin = cp; tick();
    play_req = 1'b0; coin = 1'b0;
  endtask

  // drives spin_out until busy falls; i counts cycles from the LAUNCH cycle
  task automatic run_spin(input logic [9:0] sval, input bit toggle, input bit coin_eval,
                          input int jitter);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (toggle) spin_out = i[0] ? ~sval : sval;
      else if (i < jitter) spin_out = 10'($urandom_range(0, 700));
      else spin_out = sval;
      coin = coin_eval && (i == 17);
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    coin = 1'b0;
    chk("spin_done", 32'(ok), 32'd1);
    tick();
  endtask

  initial begin
    int s0, p0, f0, v0, mc, nc, sv, jit;
    bit mwin, to, w;

    vecs[0] = '{3,   1'b0, 1'b0, 1'b0, 1'b1, 10'd42,  12,      1'b1, 1, 0};
    vecs[1] = '{3,   1'b0, 1'b0, 1'b0, 1'b0, 10'd42,  2,       1'b0, 0, 0};
    vecs[2] = '{5,   1'b1, 1'b0, 1'b0, 1'b0, 10'd9,   5,       1'b0, 0, 0};
    vecs[3] = '{254, 1'b0, 1'b1, 1'b0, 1'b1, 10'd42,  255,     1'b1, 1, 0};
    vecs[4] = '{2,   1'b0, 1'b0, 1'b1, 1'b1, 10'd85,  2,       1'b0, 0, 1};
    vecs[5] = '{1,   1'b0, 1'b0, 1'b0, 1'b1, 10'd777, JP_CRED, 1'b1, 1, 0};
    vecs[6] = '{256, 1'b0, 1'b0, 1'b0, 1'b0, 10'd3,   254,     1'b0, 0, 0};
    vecs[7] = '{250, 1'b0, 1'b0, 1'b0, 1'b1, 10'd600, 255,     1'b1, 1, 0};

    // reset state and refused play with zero credits
    do_reset();
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_credits", 32'(credits), 32'd0);
    chk("rst_win", 32'(win_flag), 32'd0);
    chk("rst_payout", 32'(payout_pulse), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    s0 = n_start;
    play_req = 1'b1; tick(); play_req = 1'b0; tick(); tick();
    chk("nocred_start", 32'(n_start - s0), 32'd0);
    chk("nocred_busy", 32'(busy), 32'd0);

    foreach (vecs[k]) begin
      do_reset();
      add_coins(vecs[k].coins);
      chk($sformatf("v%0d_coins", k), 32'(credits), 32'(sat(vecs[k].coins)));
      s0 = n_start; p0 = n_pay; f0 = n_fault; v0 = start_viol;
      won = vecs[k].w;
      launch(vecs[k].coin_play);
      chk($sformatf("v%0d_start", k), 32'(start), 32'd1);
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'd1);
      chk($sformatf("v%0d_launch_cred", k), 32'(credits),
          32'(sat(vecs[k].coins) - 1 + int'(vecs[k].coin_play)));
      run_spin(vecs[k].sval, vecs[k].toggle, vecs[k].coin_eval, 0);
      chk($sformatf("v%0d_credits", k), 32'(credits), 32'(vecs[k].exp_cred));
      chk($sformatf("v%0d_win", k), 32'(win_flag), 32'(vecs[k].exp_win));
      chk($sformatf("v%0d_pay", k), 32'(n_pay - p0), 32'(vecs[k].exp_pay));
      chk($sformatf("v%0d_fault", k), 32'(n_fault - f0), 32'(vecs[k].exp_fault));
      chk($sformatf("v%0d_nstart", k), 32'(n_start - s0), 32'd1);
      chk($sformatf("v%0d_startviol", k), 32'(start_viol - v0), 32'd0);
    end

    // win then loss clears win_flag
    do_reset();
    add_coins(3);
    won = 1'b1; launch(1'b0); run_spin(10'd42, 1'b0, 1'b0, 0);
    chk("seq_win_flag", 32'(win_flag), 32'd1);
    chk("seq_win_cred", 32'(credits), 32'd12);
    p0 = n_pay;
    won = 1'b0; launch(1'b0); run_spin(10'd42, 1'b0, 1'b0, 0);
    chk("seq_loss_flag", 32'(win_flag), 32'd0);
    chk("seq_loss_pay", 32'(n_pay - p0), 32'd0);
    chk("seq_loss_cred", 32'(credits), 32'd11);

    // held levels count once; play edges while busy are dropped
    do_reset();
    add_coins(3);
    coin = 1'b1; repeat (5) tick(); coin = 1'b0; tick();
    chk("coin_level", 32'(credits), 32'd4);
    s0 = n_start; won = 1'b0;
    play_req = 1'b1; tick();
    run_spin(10'd5, 1'b0, 1'b0, 0);
    repeat (5) tick();
    play_req = 1'b0; tick();
    chk("play_level_starts", 32'(n_start - s0), 32'd1);
    chk("play_level_cred", 32'(credits), 32'd3);
    s0 = n_start;
    launch(1'b0);
    spin_out = 10'd7; tick(); tick();
    play_req = 1'b1; tick(); play_req = 1'b0;
    run_spin(10'd7, 1'b0, 1'b0, 0);
    chk("busy_drop_starts", 32'(n_start - s0), 32'd1);
    chk("busy_drop_cred", 32'(credits), 32'd2);

    // reset mid-spin aborts without refund
    p0 = n_pay; f0 = n_fault;
    won = 1'b1; launch(1'b0);
    spin_out = 10'd11; repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_cred", 32'(credits), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (30) tick();
    chk("midrst_idle", 32'(busy), 32'd0);
    chk("midrst_pay", 32'(n_pay - p0), 32'd0);
    chk("midrst_fault", 32'(n_fault - f0), 32'd0);

    // randomized play against a transaction-level credit model
    do_reset();
    mc = 0; mwin = 1'b0;
    for (int t = 0; t < 40; t++) begin
      nc = $urandom_range(0, 3);
      add_coins(nc);
      mc = sat(mc + nc);
      s0 = n_start; f0 = n_fault;
      if (mc < 1) begin
        play_req = 1'b1; tick(); play_req = 1'b0; tick();
        chk("rnd_refused", 32'(n_start - s0), 32'd0);
      end else begin
        to  = ($urandom_range(0, 7) == 0);
        w   = 1'($urandom_range(0, 1));
        sv  = $urandom_range(0, 700);
        jit = $urandom_range(0, 10);
        won = w;
        launch(1'b0);
        run_spin(10'(sv), to, 1'b0, jit);
        mc = mc - 1;
        if (to) begin
          mc = sat(mc + 1);
        end else begin
          mwin = w;
          if (w) mc = sat(mc + 10);
        end
        chk("rnd_credits", 32'(credits), 32'(mc));
        chk("rnd_win", 32'(win_flag), 32'(mwin));
        chk("rnd_fault", 32'(n_fault - f0), 32'(to));
        chk("rnd_starts", 32'(n_start - s0), 32'd1);
      end
    end
    chk("rnd_startviol", 32'(start_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
